exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Parametrised exception/interrupt controller for the LEGv8 core; replaces the
//  combinational EStatus/Exc/ExtIAck logic that sat inside the controller.
//  Latches NIRQ maskable external IRQ lines plus the decoder's invalid-opcode flag.
//  Prioritises them and runs an exception FSM handshaking with the datapath (exc_ack)
//  and the handler return (eret). Sits beside controller; its outputs feed the datapath.
// PARAMETERS
//  NIRQ  4  number of external IRQ lines (1..8)
//  ESW   4  EStatus width; must be >= 4
// PORTS
//  clk           in   1     core clock
//  reset         in   1     asynchronous, active-high reset
//  irq           in   NIRQ  external interrupt requests, active-high
//  irq_mask      in   NIRQ  1 = line enabled; masked lines never set pending
//  not_an_instr  in   1     from maindec: current opcode invalid (synchronous exc)
//  eret          in   1     from maindec: ERET executing (handler return)
//  exc_ack       in   1     datapath has taken the exception (vector fetched)
//  exc           out  1     exception request to datapath
//  estatus       out  ESW   cause code of exception in progress
//  ext_iack      out  NIRQ  one-hot, 1-cycle acknowledge to the served IRQ line
//  irq_pend      out  NIRQ  pending IRQ bits (status/debug)
//  busy          out  1     FSM not in S_IDLE
// BEHAVIOUR
//  Reset (async): state=S_IDLE, irq_pend=0, estatus=0, exc=0, ext_iack=0, busy=0.
//  Cause codes: 0 none; 2 invalid instr; 3 double fault; 8+i IRQ line i.
//  Pending: irq_pend[i] sets at edge where irq[i]&irq_mask[i]; clears on the edge
//   ext_iack[i] is issued; set wins over clear the same cycle (level IRQ re-pends).
//  FSM (registered, 3 states):
//   S_IDLE: not_an_instr -> S_PEND, estatus=2 (1-cycle latency, exc high next cycle);
//     else any irq_pend -> S_PEND, estatus=8+lowest pending index (exc 2 cycles after irq);
//     not_an_instr beats IRQs; IRQ stays pending. exc_ack/eret ignored.
//   S_PEND: exc=1, estatus held. exc_ack -> S_HANDLER; if cause is IRQ i, ext_iack[i]=1
//     for that one cycle (registered pulse). New IRQs only accumulate in irq_pend.
//   S_HANDLER: exc=0, estatus held, IRQs not serviced (no nesting).
//     eret -> S_IDLE, estatus=0. not_an_instr (without eret) -> S_PEND, estatus=3.
//     eret and not_an_instr same cycle: eret wins.
//  Pending IRQ at eret is served from S_IDLE on the following cycle.
//  Masking a line clears nothing already pending; mask is checked only at set time.
//  Reset in any state aborts: all outputs return to reset values immediately.
//  busy = (state != S_IDLE).
// CONFIGURATION
//  EXC_IRQ_EDGE_EN defined: irq_pend[i] sets only on a 0->1 transition of irq[i]
//   (one sync stage irq_q, reset 0). A held line pends once per edge.
//  Not defined: level-sensitive as above; a held line re-pends after every ack.
// STRUCTURE
//  Package exc_pkg: exc_state_t enum {S_IDLE,S_PEND,S_HANDLER}; ESTATUS_NONE=0,
//   ESTATUS_INV_INSTR=2, ESTATUS_DBL_FAULT=3, ESTATUS_IRQ_BASE=8.
//  Sub-module prio_enc #(N): lowest-index-first priority encoder
//   (valid + index outputs), instantiated on irq_pend.
// TESTING
//  1 irq=4'b0100, mask=4'hF -> pend[2] next edge; exc=1, estatus=4'hA next;
//    exc_ack -> ext_iack=4'b0100 one cycle, S_HANDLER; eret -> estatus=0, S_IDLE.
//  2 irq=4'b0110 together -> line 1 served first (estatus=9); line 2 (estatus=10)
//    after eret, with no idle gap beyond one cycle.
//  3 not_an_instr and irq[0] in same S_IDLE cycle -> estatus=2 first; pend[0]
//    retained, served after eret (estatus=8).
//  4 not_an_instr in S_HANDLER -> S_PEND, estatus=3, exc=1. irq[3] with mask[3]=0
//    -> pend stays 0, no exc.
//  5 reset pulse mid-S_PEND -> exc/estatus/irq_pend/busy=0 asynchronously.
//    EXC_IRQ_EDGE_EN: irq[0] held high 10 cycles -> exactly one service.
//    Without it -> repeated service after each eret.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and cause codes for the LEGv8 exception/interrupt controller.
package exc_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PEND,
      S_HANDLER
   } exc_state_t;

   localparam int ESTATUS_NONE      = 0;
   localparam int ESTATUS_INV_INSTR = 2;
   localparam int ESTATUS_DBL_FAULT = 3;
   localparam int ESTATUS_IRQ_BASE  = 8;

   // Index width for an N-entry vector; never zero so N=1 still elaborates.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Request/acknowledge and status bundle between the exception controller and the core.
interface exc_ctrl_if #(
   parameter int NIRQ = 4,
   parameter int ESW  = 4
);
   logic [NIRQ-1:0] irq;
   logic [NIRQ-1:0] irq_mask;
   logic            not_an_instr;
   logic            eret;
   logic            exc_ack;
   logic            exc;
   logic [ESW-1:0]  estatus;
   logic [NIRQ-1:0] ext_iack;
   logic [NIRQ-1:0] irq_pend;
   logic            busy;

   modport master (
      output irq, irq_mask, not_an_instr, eret, exc_ack,
      input  exc, estatus, ext_iack, irq_pend, busy
   );

   modport slave (
      input  irq, irq_mask, not_an_instr, eret, exc_ack,
      output exc, estatus, ext_iack, irq_pend, busy
   );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the pending IRQ vector.
module prio_enc
   import exc_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]              req,
   output logic                      valid,
   output logic [idx_width(N)-1:0]   idx
);

   localparam int IW = idx_width(N);

   always_comb begin
      valid = |req;
      idx   = '0;
      // Walk downward so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: latches masked IRQs and invalid-opcode traps, runs the
// exception handshake FSM. Define EXC_IRQ_EDGE_EN for rising-edge IRQ capture.
//
// state     | meaning
// S_IDLE    | no exception in progress, watching traps and pending IRQs
// S_PEND    | exc raised, waiting for the datapath to take the vector
// S_HANDLER | handler running, waiting for ERET (a trap here is a double fault)
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int NIRQ = 4,
   parameter int ESW  = 4
) (
   input logic       clk,
   input logic       reset,
   exc_ctrl_if.slave bus
);

   localparam int IW = idx_width(NIRQ);

   exc_state_t      state;
   logic [NIRQ-1:0] pend_set;
   logic [NIRQ-1:0] pend_clr;
   logic [NIRQ-1:0] iack_vec;
   logic [ESW-1:0]  cause_line;
   logic            cause_irq;
   logic            pend_valid;
   logic [IW-1:0]   pend_idx;

`ifdef EXC_IRQ_EDGE_EN
   logic [NIRQ-1:0] irq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= '0;
      else       irq_q <= bus.irq;
   end

   assign pend_set = bus.irq & ~irq_q & bus.irq_mask;
`else
   assign pend_set = bus.irq & bus.irq_mask;
`endif

   // The served line is recovered from the held cause code rather than stored twice.
   assign cause_irq  = (bus.estatus >= ESW'(ESTATUS_IRQ_BASE));
   assign cause_line = bus.estatus - ESW'(ESTATUS_IRQ_BASE);
   assign iack_vec   = NIRQ'(1) << cause_line;
   assign pend_clr   = (state == S_PEND && bus.exc_ack && cause_irq) ? iack_vec : '0;

   prio_enc #(.N(NIRQ)) u_prio (
      .req   (bus.irq_pend),
      .valid (pend_valid),
      .idx   (pend_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bus.irq_pend <= '0;
      else       bus.irq_pend <= (bus.irq_pend & ~pend_clr) | pend_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         bus.estatus  <= ESW'(ESTATUS_NONE);
         bus.exc      <= 1'b0;
         bus.ext_iack <= '0;
         bus.busy     <= 1'b0;
      end else begin
         bus.ext_iack <= '0;
         case (state)
            S_IDLE: begin
               if (bus.not_an_instr) begin
                  state       <= S_PEND;
                  bus.estatus <= ESW'(ESTATUS_INV_INSTR);
                  bus.exc     <= 1'b1;
                  bus.busy    <= 1'b1;
               end else if (pend_valid) begin
                  state       <= S_PEND;
                  bus.estatus <= ESW'(ESTATUS_IRQ_BASE) + ESW'(pend_idx);
                  bus.exc     <= 1'b1;
                  bus.busy    <= 1'b1;
               end
            end
            S_PEND: begin
               if (bus.exc_ack) begin
                  state   <= S_HANDLER;
                  bus.exc <= 1'b0;
                  if (cause_irq) bus.ext_iack <= iack_vec;
               end
            end
            S_HANDLER: begin
               if (bus.eret) begin
                  state       <= S_IDLE;
                  bus.estatus <= ESW'(ESTATUS_NONE);
                  bus.busy    <= 1'b0;
               end else if (bus.not_an_instr) begin
                  state       <= S_PEND;
                  bus.estatus <= ESW'(ESTATUS_DBL_FAULT);
                  bus.exc     <= 1'b1;
               end
            end
            default: begin
               state       <= S_IDLE;
               bus.estatus <= ESW'(ESTATUS_NONE);
               bus.exc     <= 1'b0;
               bus.busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, corner sequences, random vs model.
module tb_exc_ctrl;

   localparam int NIRQ = 4;
   localparam int ESW  = 4;

   logic clk;
   logic reset;

   exc_ctrl_if #(.NIRQ(NIRQ), .ESW(ESW)) bus ();

   exc_ctrl #(.NIRQ(NIRQ), .ESW(ESW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural reference: "request outstanding" / "handler running" flags plus cause.
   logic [3:0] m_pend, m_prev_irq, m_iack;
   int         m_cause;
   bit         m_req, m_hnd;

   typedef struct {
      logic [3:0] irq, mask;
      logic       nai, er, ack;
      logic       e_exc;
      logic [3:0] e_est, e_iack, e_pend;
      logic       e_busy;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_prev_irq = '0; m_iack = '0;
      m_cause = 0; m_req = 0; m_hnd = 0;
   endtask

   task automatic model_step(input logic [3:0] irq, mask, input logic nai, er, ack);
      logic [3:0] set, clr;
      bit found;
      set = irq & mask;
`ifdef EXC_IRQ_EDGE_EN
      set = set & ~m_prev_irq;
`endif
      m_prev_irq = irq;
      clr = '0;
      m_iack = '0;
      if (m_req) begin
         if (ack) begin
            m_req = 0;
            m_hnd = 1;
            if (m_cause >= 8) begin
               m_iack[m_cause-8] = 1'b1;
               clr = m_iack;
            end
         end
      end else if (m_hnd) begin
         if (er) begin
            m_hnd = 0; m_cause = 0;
         end else if (nai) begin
            m_hnd = 0; m_req = 1; m_cause = 3;
         end
      end else begin
         if (nai) begin
            m_req = 1; m_cause = 2;
         end else begin
            found = 0;
            for (int i = 0; i < NIRQ; i++) begin
               if (m_pend[i] && !found) begin
                  found = 1; m_req = 1; m_cause = 8 + i;
               end
            end
         end
      end
      m_pend = (m_pend & ~clr) | set;
   endtask

   // Called at a falling edge: drive, advance model, clock, compare at next falling edge.
   task automatic tick(input logic [3:0] irq, mask, input logic nai, er, ack);
      bus.irq = irq; bus.irq_mask = mask;
      bus.not_an_instr = nai; bus.eret = er; bus.exc_ack = ack;
      model_step(irq, mask, nai, er, ack);
      @(posedge clk);
      @(negedge clk);
      check("model_exc",  int'(bus.exc),      int'(m_req));
      check("model_est",  int'(bus.estatus),  m_cause);
      check("model_iack", int'(bus.ext_iack), int'(m_iack));
      check("model_pend", int'(bus.irq_pend), int'(m_pend));
      check("model_busy", int'(bus.busy),     int'(m_req | m_hnd));
   endtask

   task automatic add(input logic [3:0] irq, mask, input logic nai, er, ack,
                      input logic e_exc, input logic [3:0] e_est, e_iack, e_pend,
                      input logic e_busy);
      vec_t v;
      v.irq = irq; v.mask = mask; v.nai = nai; v.er = er; v.ack = ack;
      v.e_exc = e_exc; v.e_est = e_est; v.e_iack = e_iack; v.e_pend = e_pend;
      v.e_busy = e_busy;
      vt.push_back(v);
   endtask

   int iack_cnt;

   initial begin
      model_reset();
      reset = 1'b1;
      bus.irq = '0; bus.irq_mask = '0;
      bus.not_an_instr = 0; bus.eret = 0; bus.exc_ack = 0;
      repeat (2) @(negedge clk);
      check("rst_exc",  int'(bus.exc),      0);
      check("rst_est",  int'(bus.estatus),  0);
      check("rst_iack", int'(bus.ext_iack), 0);
      check("rst_pend", int'(bus.irq_pend), 0);
      check("rst_busy", int'(bus.busy),     0);
      reset = 1'b0;

      //   irq      mask    nai er ack | exc est   iack     pend     busy
      add(4'b0100, 4'hF, 0, 0, 0,  0, 4'h0, 4'b0000, 4'b0100, 0);
      add(4'b0000, 4'hF, 0, 0, 0,  1, 4'hA, 4'b0000, 4'b0100, 1);
      add(4'b0000, 4'hF, 0, 0, 1,  0, 4'hA, 4'b0100, 4'b0000, 1);
      add(4'b0000, 4'hF, 0, 0, 0,  0, 4'hA, 4'b0000, 4'b0000, 1);
      add(4'b0000, 4'hF, 0, 1, 0,  0, 4'h0, 4'b0000, 4'b0000, 0);
      add(4'b0110, 4'hF, 0, 0, 0,  0, 4'h0, 4'b0000, 4'b0110, 0);
      add(4'b0000, 4'hF, 0, 0, 0,  1, 4'h9, 4'b0000, 4'b0110, 1);
      add(4'b0000, 4'hF, 0, 0, 1,  0, 4'h9, 4'b0010, 4'b0100, 1);
      add(4'b0000, 4'hF, 0, 1, 0,  0, 4'h0, 4'b0000, 4'b0100, 0);
      add(4'b0000, 4'hF, 0, 0, 0,  1, 4'hA, 4'b0000, 4'b0100, 1);
      add(4'b0000, 4'hF, 0, 0, 1,  0, 4'hA, 4'b0100, 4'b0000, 1);
      add(4'b0000, 4'hF, 0, 1, 0,  0, 4'h0, 4'b0000, 4'b0000, 0);
      add(4'b0001, 4'hF, 1, 0, 0,  1, 4'h2, 4'b0000, 4'b0001, 1);
      add(4'b0000, 4'hF, 0, 0, 1,  0, 4'h2, 4'b0000, 4'b0001, 1);
      add(4'b0000, 4'hF, 0, 1, 0,  0, 4'h0, 4'b0000, 4'b0001, 0);
      add(4'b0000, 4'hF, 0, 0, 0,  1, 4'h8, 4'b0000, 4'b0001, 1);
      add(4'b0000, 4'hF, 0, 0, 1,  0, 4'h8, 4'b0001, 4'b0000, 1);
      add(4'b0000, 4'hF, 1, 0, 0,  1, 4'h3, 4'b0000, 4'b0000, 1);
      add(4'b0000, 4'hF, 0, 0, 1,  0, 4'h3, 4'b0000, 4'b0000, 1);
      add(4'b0000, 4'hF, 0, 1, 0,  0, 4'h0, 4'b0000, 4'b0000, 0);
      add(4'b1000, 4'h7, 0, 0, 0,  0, 4'h0, 4'b0000, 4'b0000, 0);
      add(4'b1000, 4'h7, 0, 0, 0,  0, 4'h0, 4'b0000, 4'b0000, 0);
      add(4'b0000, 4'hF, 0, 0, 0,  0, 4'h0, 4'b0000, 4'b0000, 0);

      foreach (vt[k]) begin
         tick(vt[k].irq, vt[k].mask, vt[k].nai, vt[k].er, vt[k].ack);
         check($sformatf("vec%0d_exc", k),  int'(bus.exc),      int'(vt[k].e_exc));
         check($sformatf("vec%0d_est", k),  int'(bus.estatus),  int'(vt[k].e_est));
         check($sformatf("vec%0d_iack", k), int'(bus.ext_iack), int'(vt[k].e_iack));
         check($sformatf("vec%0d_pend", k), int'(bus.irq_pend), int'(vt[k].e_pend));
         check($sformatf("vec%0d_busy", k), int'(bus.busy),     int'(vt[k].e_busy));
      end

      // eret and a trap together in the handler: return wins.
      tick(4'b0000, 4'hF, 1, 0, 0);
      tick(4'b0000, 4'hF, 0, 0, 1);
      tick(4'b0000, 4'hF, 1, 1, 0);
      check("eret_wins_exc",  int'(bus.exc),     0);
      check("eret_wins_est",  int'(bus.estatus), 0);
      check("eret_wins_busy", int'(bus.busy),    0);

      // Asynchronous reset while an IRQ request is outstanding.
      tick(4'b0001, 4'hF, 0, 0, 0);
      tick(4'b0000, 4'hF, 0, 0, 0);
      check("pre_rst_exc", int'(bus.exc), 1);
      #2 reset = 1'b1;
      #1;
      check("arst_exc",  int'(bus.exc),      0);
      check("arst_est",  int'(bus.estatus),  0);
      check("arst_pend", int'(bus.irq_pend), 0);
      check("arst_busy", int'(bus.busy),     0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Held line with an immediately responsive handler.
      iack_cnt = 0;
      for (int c = 0; c < 18; c++) begin
         tick((c < 10) ? 4'b0001 : 4'b0000, 4'hF, 0, m_hnd, m_req);
         if (bus.ext_iack[0]) iack_cnt++;
      end
`ifdef EXC_IRQ_EDGE_EN
      check("held_services", iack_cnt, 1);
`else
      check("held_services", int'(iack_cnt >= 2), 1);
`endif
      repeat (4) tick(4'b0000, 4'hF, 0, m_hnd, m_req);

      for (int c = 0; c < 400; c++) begin
         tick(4'($urandom), 4'($urandom), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
